// File: rtl/ws_tile_sequencer_pkg.sv
// Shared widths, state types and the instruction-word packer used by the
// weight-stationary tile sequencer and its pmem drain sub-FSM.
package core_pkg;

  localparam int AW = 11;
  localparam int NW = 7;
  localparam int CW = 8;

  localparam int B_LOAD     = 0;
  localparam int B_EXECUTE  = 1;
  localparam int B_L0_WR    = 2;
  localparam int B_L0_RD    = 3;
  localparam int B_OFIFO_RD = 6;
  localparam int B_A_XMEM   = 7;
  localparam int B_WEN_XMEM = 18;
  localparam int B_CEN_XMEM = 19;
  localparam int B_A_PMEM   = 20;
  localparam int B_WEN_PMEM = 31;
  localparam int B_CEN_PMEM = 32;
  localparam int B_ACC      = 33;
  localparam int B_PASS     = 34;
  localparam int B_REN_PMEM = 35;

  // Both memories deselected with write disabled; nothing else asserted.
  localparam logic [63:0] INST_IDLE = 64'h0000_0001_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_W_XFER, S_W_LOAD, S_W_GAP, S_A_XFER, S_EXEC, S_DRAIN, S_DONE
  } state_e;

  typedef enum logic [1:0] {D_WAIT, D_RD, D_WR} drain_state_e;

  typedef struct packed {
    logic          load;
    logic          execute;
    logic          l0_wr;
    logic          l0_rd;
    logic          ofifo_rd;
    logic [AW-1:0] a_xmem;
    logic          wen_xmem;
    logic          cen_xmem;
    logic [AW-1:0] a_pmem;
    logic          wen_pmem;
    logic          cen_pmem;
    logic          acc;
    logic          passthrough;
    logic          ren_pmem;
  } inst_fields_t;

  typedef struct packed {
    logic          cen;
    logic          wen;
    logic          ren;
    logic          acc;
    logic          pass;
    logic          ofifo_rd;
    logic [AW-1:0] addr;
  } pmem_req_t;

  function automatic logic [63:0] pack_inst(input inst_fields_t f);
    logic [63:0] w;
    w = 64'd0;
    w[B_LOAD]            = f.load;
    w[B_EXECUTE]         = f.execute;
    w[B_L0_WR]           = f.l0_wr;
    w[B_L0_RD]           = f.l0_rd;
    w[B_OFIFO_RD]        = f.ofifo_rd;
    w[B_A_XMEM +: AW]    = f.a_xmem;
    w[B_WEN_XMEM]        = f.wen_xmem;
    w[B_CEN_XMEM]        = f.cen_xmem;
    w[B_A_PMEM +: AW]    = f.a_pmem;
    w[B_WEN_PMEM]        = f.wen_pmem;
    w[B_CEN_PMEM]        = f.cen_pmem;
    w[B_ACC]             = f.acc;
    w[B_PASS]            = f.passthrough;
    w[B_REN_PMEM]        = f.ren_pmem;
    return w;
  endfunction

endpackage

// File: rtl/ws_tile_sequencer_if.sv
// Host/core-facing bundle of the tile sequencer: start/done handshake,
// latched tile parameters, OFIFO status and the core instruction word.
interface ws_tile_sequencer_if;
  import core_pkg::*;

  logic          start;
  logic [AW-1:0] w_base;
  logic [AW-1:0] x_base;
  logic [AW-1:0] p_base;
  logic [NW-1:0] n_act;
  logic          acc_en;
  logic          ofifo_valid;
  logic [63:0]   inst;
  logic          busy;
  logic          done;

  modport master (
    output start, w_base, x_base, p_base, n_act, acc_en, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, w_base, x_base, p_base, n_act, acc_en, ofifo_valid,
    output inst, busy, done
  );

endinterface

// File: rtl/ws_tile_sequencer_pmem_drain.sv
// DRAIN sub-FSM: moves OFIFO vectors into pmem, either as a plain write or
// as a read/accumulate-write pair. req describes the word for the next cycle.
module pmem_drain
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          acc_en,
  input  logic          ofifo_valid,
  input  logic [NW-1:0] n_act,
  input  logic [AW-1:0] p_base,
  output logic          fin,
  output pmem_req_t     req
);

  drain_state_e  ds_q, ds_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;

  // Last entry is complete once its write cycle is the one being issued now.
  assign fin = (cnt_q == n_act) && (ds_q != D_RD);

  // Entry sequencing; a read already issued always commits its write.
  always_comb begin
    ds_d   = D_WAIT;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (!go) begin
      ds_d   = D_WAIT;
      cnt_d  = '0;
      addr_d = '0;
    end else if (ds_q == D_RD) begin
      ds_d = D_WR;
    end else if ((cnt_q != n_act) && ofifo_valid) begin
      ds_d   = acc_en ? D_RD : D_WR;
      addr_d = p_base + {{(AW-NW){1'b0}}, cnt_q};
      cnt_d  = cnt_q + NW'(1);
    end else begin
      ds_d = D_WAIT;
    end
  end

  // Memory controls for the upcoming cycle, decoded from the next state.
  always_comb begin
    req.cen      = (ds_d == D_WAIT);
    req.wen      = (ds_d != D_WR);
    req.ren      = (ds_d == D_RD);
    req.acc      = (ds_d == D_WR) && acc_en;
    req.pass     = (ds_d == D_WR) && !acc_en;
    req.ofifo_rd = (ds_d == D_WR);
    req.addr     = (ds_d == D_WAIT) ? {AW{1'b0}} : addr_d;
  end

  // State, entry count and current pmem address.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_q   <= D_WAIT;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      ds_q   <= ds_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/ws_tile_sequencer.sv
// Weight-stationary tile sequencer: walks weight fetch/load, activation
// fetch/execute and pmem drain, emitting one registered core word per cycle.
module ws_tile_sequencer
  import core_pkg::*;
#(
  parameter int ROW = 8,
  parameter int COL = 8
) (
  input logic                clk,
  input logic                reset,
  ws_tile_sequencer_if.slave bus
);

  localparam logic [CW-1:0] XFER_W    = CW'(COL);
  localparam logic [CW-1:0] LOAD_LAST = CW'(COL - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(ROW + COL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
  logic [NW-1:0] n_q, n_d;
  logic          acc_q, acc_d;
  logic [63:0]   inst_q, inst_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          drain_go, drain_fin;
  pmem_req_t     pm_req;
  inst_fields_t  f;
  logic [CW-1:0] xfer_len;
  logic [AW-1:0] xfer_base;

  // Phase sequencing; the phase counter indexes the cycle within a phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    p_base_d = p_base_q;
    n_d      = n_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d  = S_W_XFER;
          w_base_d = bus.w_base;
          x_base_d = bus.x_base;
          p_base_d = bus.p_base;
          n_d      = bus.n_act;
          acc_d    = bus.acc_en;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_XFER: if (cnt_q == XFER_W) begin state_d = S_W_LOAD; cnt_d = '0; end
                else begin state_d = S_W_XFER; end
      S_W_LOAD: if (cnt_q == LOAD_LAST) begin state_d = S_W_GAP; cnt_d = '0; end
                else begin state_d = S_W_LOAD; end
      S_W_GAP: if (cnt_q == GAP_LAST) begin
                 state_d = (n_q == '0) ? S_DONE : S_A_XFER;
                 cnt_d   = '0;
               end else begin
                 state_d = S_W_GAP;
               end
      S_A_XFER: if (cnt_q == CW'(n_q)) begin state_d = S_EXEC; cnt_d = '0; end
                else begin state_d = S_A_XFER; end
      S_EXEC: if (cnt_q == CW'(n_q) - CW'(1)) begin state_d = S_DRAIN; cnt_d = '0; end
              else begin state_d = S_EXEC; end
      S_DRAIN: begin
        cnt_d   = '0;
        state_d = drain_fin ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign drain_go = (state_d == S_DRAIN);

  pmem_drain u_drain (
    .clk         (clk),
    .reset       (reset),
    .go          (drain_go),
    .acc_en      (acc_q),
    .ofifo_valid (bus.ofifo_valid),
    .n_act       (n_q),
    .p_base      (p_base_q),
    .fin         (drain_fin),
    .req         (pm_req)
  );

  // Word for the next cycle, decoded from next state so outputs stay registered.
  always_comb begin
    f          = '0;
    f.wen_xmem = 1'b1;
    f.cen_xmem = 1'b1;
    f.wen_pmem = 1'b1;
    f.cen_pmem = 1'b1;
    xfer_len   = (state_d == S_A_XFER) ? CW'(n_d) : XFER_W;
    xfer_base  = (state_d == S_A_XFER) ? x_base_d : w_base_d;
    case (state_d)
      S_W_XFER, S_A_XFER: begin
        // L0 write trails the SRAM read by its one-cycle latency.
        f.l0_wr = (cnt_d != '0);
        if (cnt_d < xfer_len) begin
          f.cen_xmem = 1'b0;
          f.a_xmem   = xfer_base + AW'(cnt_d);
        end else begin
          f.cen_xmem = 1'b1;
        end
      end
      S_W_LOAD: begin
        f.l0_rd = 1'b1;
        f.load  = 1'b1;
      end
      S_EXEC: begin
        f.l0_rd   = 1'b1;
        f.execute = 1'b1;
      end
      S_DRAIN: begin
        f.cen_pmem    = pm_req.cen;
        f.wen_pmem    = pm_req.wen;
        f.ren_pmem    = pm_req.ren;
        f.acc         = pm_req.acc;
        f.passthrough = pm_req.pass;
        f.ofifo_rd    = pm_req.ofifo_rd;
        f.a_pmem      = pm_req.addr;
      end
      default: f.load = 1'b0;
    endcase
    inst_d = pack_inst(f);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, counters, latched tile parameters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      n_q      <= '0;
      acc_q    <= 1'b0;
      inst_q   <= INST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
